// File: rtl/mmu_sequencer.sv
// Host-side sequencer for the 2x2 systolic MMU feeder: gathers eight operand bytes
// (four weights, then four inputs), then steps the feeder through one compute pass.
// Optional build macro: MMU_SEQ_WEIGHT_REUSE_EN (adds reuse_weights, 4-byte loads).
module mmu_sequencer #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LAST_CYCLE = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    // Handshake: a byte is accepted on every rising edge where host_load=1 and
    // load_ready=1 (abort=0); host_load while load_ready=0 discards the byte and sets overrun.
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_load,
    input  logic              abort,
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
    input  logic              reuse_weights,
`endif
    output logic [DATA_W-1:0] weight0,
    output logic [DATA_W-1:0] weight1,
    output logic [DATA_W-1:0] weight2,
    output logic [DATA_W-1:0] weight3,
    output logic [DATA_W-1:0] input0,
    output logic [DATA_W-1:0] input1,
    output logic [DATA_W-1:0] input2,
    output logic [DATA_W-1:0] input3,
    output logic              mmu_en,
    output logic [2:0]        mmu_cycle,
    output logic              load_ready,
    output logic              busy,
    output logic              overrun,
    output logic [7:0]        pass_count
);

    localparam logic [2:0] LAST_C = 3'(LAST_CYCLE);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        load_cnt_q, load_cnt_d;
    logic [DATA_W-1:0] opnd_q [8];
    logic [DATA_W-1:0] opnd_d [8];
    logic              mmu_en_q, mmu_en_d;
    logic [2:0]        mmu_cycle_q, mmu_cycle_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        pass_count_q, pass_count_d;
    logic [2:0]        slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            load_cnt_q   <= 3'd0;
            mmu_en_q     <= 1'b0;
            mmu_cycle_q  <= 3'd0;
            overrun_q    <= 1'b0;
            pass_count_q <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                opnd_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            mmu_en_q     <= mmu_en_d;
            mmu_cycle_q  <= mmu_cycle_d;
            overrun_q    <= overrun_d;
            pass_count_q <= pass_count_d;
            for (int i = 0; i < 8; i++) begin
                opnd_q[i] <= opnd_d[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        opnd_d       = opnd_q;
        mmu_en_d     = mmu_en_q;
        mmu_cycle_d  = mmu_cycle_q;
        pass_count_d = pass_count_q;
        overrun_d    = overrun_q | (host_load && (state_q == ST_RUN));
        slot         = load_cnt_q;

        if (abort) begin
            state_d     = ST_LOAD;
            load_cnt_d  = 3'd0;
            mmu_en_d    = 1'b0;
            mmu_cycle_d = 3'd0;
        end else if (state_q == ST_LOAD) begin
            if (host_load) begin
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
                // Reusing weights: first byte goes straight to input0, weights stay.
                if ((load_cnt_q == 3'd0) && reuse_weights) begin
                    slot = 3'd4;
                end
`endif
                opnd_d[slot] = host_data;
                if (slot == 3'd7) begin
                    state_d     = ST_RUN;
                    load_cnt_d  = 3'd0;
                    mmu_en_d    = 1'b1;
                    mmu_cycle_d = 3'd0;
                end else begin
                    load_cnt_d = slot + 3'd1;
                end
            end
        end else begin
            if (mmu_cycle_q == LAST_C) begin
                state_d      = ST_LOAD;
                mmu_en_d     = 1'b0;
                mmu_cycle_d  = 3'd0;
                pass_count_d = pass_count_q + 8'd1;
            end else begin
                mmu_cycle_d = mmu_cycle_q + 3'd1;
            end
        end
    end

    assign weight0    = opnd_q[0];
    assign weight1    = opnd_q[1];
    assign weight2    = opnd_q[2];
    assign weight3    = opnd_q[3];
    assign input0     = opnd_q[4];
    assign input1     = opnd_q[5];
    assign input2     = opnd_q[6];
    assign input3     = opnd_q[7];
    assign mmu_en     = mmu_en_q;
    assign mmu_cycle  = mmu_cycle_q;
    assign load_ready = (state_q == ST_LOAD);
    assign busy       = (state_q == ST_RUN);
    assign overrun    = overrun_q;
    assign pass_count = pass_count_q;

endmodule

// File: tb/tb_mmu_sequencer.sv
// Directed bench for mmu_sequencer: loads, gapped loads, overrun, abort,
// pass_count wrap and asynchronous reset mid-pass.
module tb_mmu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] host_data = 8'd0;
    logic       host_load = 1'b0;
    logic       abort = 1'b0;
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
    logic       reuse_weights = 1'b0;
`endif
    logic [7:0] weight0, weight1, weight2, weight3;
    logic [7:0] input0, input1, input2, input3;
    logic       mmu_en;
    logic [2:0] mmu_cycle;
    logic       load_ready, busy, overrun;
    logic [7:0] pass_count;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_ops [8];
    logic [7:0] exp_pass = 8'd0;

    mmu_sequencer #(.DATA_W(8), .LAST_CYCLE(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_data  (host_data),
        .host_load  (host_load),
        .abort      (abort),
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
        .reuse_weights(reuse_weights),
`endif
        .weight0    (weight0),
        .weight1    (weight1),
        .weight2    (weight2),
        .weight3    (weight3),
        .input0     (input0),
        .input1     (input1),
        .input2     (input2),
        .input3     (input3),
        .mmu_en     (mmu_en),
        .mmu_cycle  (mmu_cycle),
        .load_ready (load_ready),
        .busy       (busy),
        .overrun    (overrun),
        .pass_count (pass_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_ops(input string tag);
        check({tag, "_w0"}, 32'(weight0), 32'(exp_ops[0]));
        check({tag, "_w1"}, 32'(weight1), 32'(exp_ops[1]));
        check({tag, "_w2"}, 32'(weight2), 32'(exp_ops[2]));
        check({tag, "_w3"}, 32'(weight3), 32'(exp_ops[3]));
        check({tag, "_i0"}, 32'(input0),  32'(exp_ops[4]));
        check({tag, "_i1"}, 32'(input1),  32'(exp_ops[5]));
        check({tag, "_i2"}, 32'(input2),  32'(exp_ops[6]));
        check({tag, "_i3"}, 32'(input3),  32'(exp_ops[7]));
    endtask

    task automatic set_exp(input logic [7:0] base);
        for (int i = 0; i < 8; i++) exp_ops[i] = base + 8'(i);
    endtask

    task automatic load_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            host_data = base + 8'(i);
            host_load = 1'b1;
            step();
        end
        host_load = 1'b0;
    endtask

    task automatic do_pass(input logic [7:0] base);
        load_bytes(base, 8);
        repeat (6) step();
        exp_pass = exp_pass + 8'd1;
        check("pass_cnt", 32'(pass_count), 32'(exp_pass));
    endtask

    task automatic check_reset_outputs(input string tag);
        set_exp(8'd0);
        for (int i = 0; i < 8; i++) exp_ops[i] = 8'd0;
        check_ops(tag);
        check({tag, "_en"},    32'(mmu_en),     32'd0);
        check({tag, "_cyc"},   32'(mmu_cycle),  32'd0);
        check({tag, "_ready"}, 32'(load_ready), 32'd1);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_ovr"},   32'(overrun),    32'd0);
        check({tag, "_pass"},  32'(pass_count), 32'd0);
    endtask

    initial begin
        // Reset
        #3;
        check_reset_outputs("rst");
        #9;
        rst_n = 1'b1;

        // Back-to-back load 01..08 and one full pass
        for (int i = 0; i < 8; i++) begin
            host_data = 8'(i + 1);
            host_load = 1'b1;
            step();
            if (i < 7) check("b2b_ready", 32'(load_ready), 32'd1);
        end
        host_load = 1'b0;
        set_exp(8'h01);
        check_ops("b2b");
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_ready_lo", 32'(load_ready), 32'd0);
        check("b2b_en", 32'(mmu_en), 32'd1);
        check("b2b_cyc0", 32'(mmu_cycle), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("b2b_cyc", 32'(mmu_cycle), 32'(k));
            check("b2b_en_run", 32'(mmu_en), 32'd1);
        end
        step();
        exp_pass = 8'd1;
        check("b2b_en_off", 32'(mmu_en), 32'd0);
        check("b2b_ready_back", 32'(load_ready), 32'd1);
        check("b2b_cyc_end", 32'(mmu_cycle), 32'd0);
        check("b2b_pass", 32'(pass_count), 32'd1);

        // Gapped load: strobe every third clock
        for (int i = 0; i < 8; i++) begin
            host_data = 8'h11 + 8'(i);
            host_load = 1'b1;
            step();
            host_load = 1'b0;
            if (i < 7) begin
                step();
                step();
                check("gap_ready", 32'(load_ready), 32'd1);
            end
        end
        set_exp(8'h11);
        check_ops("gap");
        check("gap_busy", 32'(busy), 32'd1);
        check("gap_cyc0", 32'(mmu_cycle), 32'd0);
        repeat (6) step();
        exp_pass = 8'd2;
        check("gap_pass", 32'(pass_count), 32'd2);
        check("gap_ovr", 32'(overrun), 32'd0);

        // host_load held through a whole pass
        for (int i = 0; i < 8; i++) begin
            host_data = 8'h21 + 8'(i);
            host_load = 1'b1;
            step();
        end
        check("hold_ovr_pre", 32'(overrun), 32'd0);
        set_exp(8'h21);
        for (int k = 1; k <= 6; k++) begin
            host_data = 8'hE0 + 8'(k);
            step();
            check("hold_ovr", 32'(overrun), 32'd1);
            if (k < 6) check_ops("hold_frozen");
        end
        exp_pass = 8'd3;
        check("hold_ready", 32'(load_ready), 32'd1);
        check("hold_pass", 32'(pass_count), 32'd3);
        check("hold_w0_kept", 32'(weight0), 32'h21);
        host_data = 8'h31;
        step();
        check("hold_w0_new", 32'(weight0), 32'h31);
        for (int i = 1; i < 8; i++) begin
            host_data = 8'h31 + 8'(i);
            step();
        end
        host_load = 1'b0;
        set_exp(8'h31);
        check_ops("hold_reload");
        check("hold_busy", 32'(busy), 32'd1);

        // Abort at mmu_cycle=3
        repeat (3) step();
        check("abort_cyc3", 32'(mmu_cycle), 32'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_en", 32'(mmu_en), 32'd0);
        check("abort_cyc", 32'(mmu_cycle), 32'd0);
        check("abort_ready", 32'(load_ready), 32'd1);
        check("abort_pass", 32'(pass_count), 32'(exp_pass));

        // Abort after 5 bytes; simultaneous host_load dropped
        load_bytes(8'h41, 5);
        abort = 1'b1;
        host_load = 1'b1;
        host_data = 8'h99;
        step();
        abort = 1'b0;
        host_load = 1'b0;
        check("abl_w0", 32'(weight0), 32'h41);
        check("abl_i0", 32'(input0), 32'h45);
        check("abl_i1", 32'(input1), 32'h36);
        load_bytes(8'h51, 4);
        check("abl_busy4", 32'(busy), 32'd0);
        for (int i = 4; i < 8; i++) begin
            host_data = 8'h51 + 8'(i);
            host_load = 1'b1;
            step();
        end
        host_load = 1'b0;
        set_exp(8'h51);
        check_ops("abl_reload");
        check("abl_busy8", 32'(busy), 32'd1);
        repeat (6) step();
        exp_pass = exp_pass + 8'd1;
        check("abl_pass", 32'(pass_count), 32'(exp_pass));

        // Run to pass_count 255 then wrap to 0
        while (exp_pass != 8'hFF) do_pass(8'(exp_pass));
        check("wrap_255", 32'(pass_count), 32'hFF);
        do_pass(8'h70);
        check("wrap_0", 32'(pass_count), 32'h00);

        // Asynchronous reset in the middle of a pass
        load_bytes(8'h61, 8);
        step();
        step();
        check("mid_cyc2", 32'(mmu_cycle), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        #3;
        rst_n = 1'b1;
        step();
        check("mid_ready", 32'(load_ready), 32'd1);

`ifdef MMU_SEQ_WEIGHT_REUSE_EN
        // Weight reuse: 4-byte load keeps weights 01..04
        load_bytes(8'h01, 8);
        repeat (6) step();
        host_data = 8'hAA;
        host_load = 1'b1;
        reuse_weights = 1'b1;
        step();
        reuse_weights = 1'b0;
        check("reuse_busy1", 32'(busy), 32'd0);
        host_data = 8'hBB; step();
        host_data = 8'hCC; step();
        check("reuse_busy3", 32'(busy), 32'd0);
        host_data = 8'hDD; step();
        host_load = 1'b0;
        set_exp(8'h01);
        exp_ops[4] = 8'hAA;
        exp_ops[5] = 8'hBB;
        exp_ops[6] = 8'hCC;
        exp_ops[7] = 8'hDD;
        check_ops("reuse");
        check("reuse_busy4", 32'(busy), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
